// File: rtl/datamem_arbiter_if.sv
// Requester, response and DataMem-side signals shared between the arbiter and its clients.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface datamem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write;
    logic [1:0]  mem_read;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter that serialises word accesses onto a single DataMem port.
// Misaligned or out-of-range accesses complete with an error and never strobe memory.
module datamem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input logic              clk,
    input logic              rst,
    datamem_arbiter_if.slave bus
);
    localparam logic [1:0]  StIdle   = 2'd0;
    localparam logic [1:0]  StAccess = 2'd1;
    localparam logic [1:0]  StResp   = 2'd2;
    localparam logic [31:0] MaxAddr  = 32'(ADDR_LIMIT - 4);

    logic [1:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;

    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;

    // prio_q names the port that wins a tie; it flips to the loser after every grant.
    always_comb begin
        sel       = (bus.req0 && bus.req1) ? prio_q : bus.req1;
        sel_we    = sel ? bus.we1 : bus.we0;
        sel_addr  = sel ? bus.addr1 : bus.addr0;
        sel_wdata = sel ? bus.wdata1 : bus.wdata0;
        sel_ok    = (sel_addr[1:0] == 2'b00) && (sel_addr <= MaxAddr);
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        we_d        = we_q;
        err_d       = err_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = sel;
                    we_d    = sel_we;
                    err_d   = !sel_ok;
                    prio_d  = !sel;
                    gnt0_d  = !sel;
                    gnt1_d  = sel;
                    // Strobes launch with the grant so DataMem acts on the following edge.
                    if (sel_ok) begin
                        mem_addr_d = sel_addr;
                        if (sel_we) begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = sel_wdata;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                done0_d     = !owner_q;
                done1_d     = owner_q;
                rsp_err_d   = err_q;
                rsp_rdata_d = (err_q || we_q) ? 32'd0 : bus.mem_rdata;
                state_d     = StResp;
            end
            StResp: begin
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_write = {1'b0, mem_write_q};
    assign bus.mem_read  = {1'b0, mem_read_q};
endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: byte-array DataMem model plus a word-level reference memory
// and a last-served pointer that predicts grants, data and errors.
module tb_datamem_arbiter;
    logic clk = 1'b0;
    logic rst;
    datamem_arbiter_if bus ();

    datamem_arbiter #(.ADDR_LIMIT(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  dm [0:255];
    logic [31:0] ref_mem [0:63];
    logic [7:0]  ra;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_last = 1;  // port served most recently in the model; 1 means port 0 wins ties

    assign ra = {bus.mem_addr[7:2], 2'b00};
    assign bus.mem_rdata = {dm[ra + 8'd3], dm[ra + 8'd2], dm[ra + 8'd1], dm[ra]};

    always @(posedge clk) begin
        if (bus.mem_write == 2'd1) begin
            dm[ra]        = bus.mem_wdata[7:0];
            dm[ra + 8'd1] = bus.mem_wdata[15:8];
            dm[ra + 8'd2] = bus.mem_wdata[23:16];
            dm[ra + 8'd3] = bus.mem_wdata[31:24];
        end
    end

    function automatic logic [31:0] dm_word(input int w);
        return {dm[4*w+3], dm[4*w+2], dm[4*w+1], dm[4*w]};
    endfunction

    function automatic logic is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic we, input logic [31:0] a);
        if (we || !is_legal(a)) return 32'd0;
        return ref_mem[a / 4];
    endfunction

    task automatic drive_req(input int port, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
        end
    endtask

    // Waits for a grant then a done, recording what was seen; no checking here.
    task automatic observe(output int gp, output int gwait, output int dlat, output int dp,
                           output logic [31:0] rd, output logic er, output int rdn,
                           output int wrn);
        gp = -1; dp = -1; gwait = 0; dlat = 0; rd = '0; er = 1'b0; rdn = 0; wrn = 0;
        for (int c = 0; c < 12 && gp < 0; c++) begin
            @(posedge clk); #1;
            gwait++;
            if (bus.gnt0) gp = 0;
            else if (bus.gnt1) gp = 1;
        end
        if (gp < 0) return;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int c = 0; c < 6 && dp < 0; c++) begin
            rdn += int'(bus.mem_read == 2'd1);
            wrn += int'(bus.mem_write == 2'd1);
            @(posedge clk); #1;
            dlat++;
            if (bus.done0) dp = 0;
            else if (bus.done1) dp = 1;
        end
        if (dp >= 0) begin
            rd = bus.rsp_rdata;
            er = bus.rsp_err;
            rdn += int'(bus.mem_read == 2'd1);
            wrn += int'(bus.mem_write == 2'd1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.rsp_err} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.rsp_err});
        end
        n_cmp++;
        if ({bus.rsp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_write, bus.mem_read} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: rdata %h addr %h wdata %h wr %0d rd %0d want all 0",
                     bus.rsp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_write, bus.mem_read);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_last = 1;
        @(negedge clk);
    endtask

    task automatic test_plan_reads();
        int gp, gw, dl, dp, rdn, wrn;
        logic [31:0] rd;
        logic er;
        drive_req(0, 1'b0, 32'h14, 32'd0);
        observe(gp, gw, dl, dp, rd, er, rdn, wrn);
        n_cmp++; if (gp !== 0 || gw !== 1) begin n_fail++;
            $display("FAIL rd14_gnt: port %0d after %0d cycles, want port 0 after 1", gp, gw); end
        n_cmp++; if (rdn !== 1 || wrn !== 0) begin n_fail++;
            $display("FAIL rd14_strobes: read %0d write %0d cycles, want 1/0", rdn, wrn); end
        n_cmp++; if (dp !== 0 || dl !== 1) begin n_fail++;
            $display("FAIL rd14_done: port %0d latency %0d, want port 0 latency 1", dp, dl); end
        n_cmp++; if (rd !== 32'h55555555 || er !== 1'b0) begin n_fail++;
            $display("FAIL rd14_data: got %h err %b want 55555555 err 0", rd, er); end
        exp_last = 0;
        drive_req(0, 1'b0, 32'h28, 32'd0);
        observe(gp, gw, dl, dp, rd, er, rdn, wrn);
        n_cmp++; if (dp !== 0 || rd !== 32'haaaaaaaa || er !== 1'b0) begin n_fail++;
            $display("FAIL rd28: port %0d data %h err %b want 0 aaaaaaaa 0", dp, rd, er); end
        exp_last = 0;
    endtask

    task automatic test_write_read();
        int gp, gw, dl, dp, rdn, wrn;
        logic [31:0] rd;
        logic er;
        drive_req(1, 1'b1, 32'h14, 32'h99999999);
        observe(gp, gw, dl, dp, rd, er, rdn, wrn);
        n_cmp++; if (gp !== 1 || dp !== 1) begin n_fail++;
            $display("FAIL wr14_port: gnt %0d done %0d want 1/1", gp, dp); end
        n_cmp++; if (wrn !== 1 || rdn !== 0) begin n_fail++;
            $display("FAIL wr14_strobes: write %0d read %0d cycles, want 1/0", wrn, rdn); end
        n_cmp++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++;
            $display("FAIL wr14_rsp: data %h err %b want 0/0", rd, er); end
        ref_mem[5] = 32'h99999999;
        exp_last = 1;
        drive_req(1, 1'b0, 32'h14, 32'd0);
        observe(gp, gw, dl, dp, rd, er, rdn, wrn);
        n_cmp++; if (rd !== 32'h99999999 || dp !== 1) begin n_fail++;
            $display("FAIL rd14_after_wr: data %h port %0d want 99999999 port 1", rd, dp); end
        exp_last = 1;
    endtask

    task automatic test_back_to_back();
        int ngnt = 0, ndone = 0, last_cyc = -100, owner = -1, wp;
        drive_req(0, 1'b0, 32'h14, 32'd0);
        drive_req(1, 1'b0, 32'h28, 32'd0);
        for (int cyc = 0; cyc < 60 && ndone < 6; cyc++) begin
            @(posedge clk); #1;
            if (bus.gnt0 || bus.gnt1) begin
                wp = (exp_last == 0) ? 1 : 0;
                n_cmp++; if (bus.gnt0 === bus.gnt1 || int'(bus.gnt1) !== wp) begin n_fail++;
                    $display("FAIL b2b_order: gnt0 %b gnt1 %b want port %0d", bus.gnt0,
                             bus.gnt1, wp); end
                if (ngnt > 0) begin
                    n_cmp++; if (cyc - last_cyc < 3) begin n_fail++;
                        $display("FAIL b2b_gap: %0d cycles between grants want >= 3",
                                 cyc - last_cyc); end
                end
                exp_last = wp; owner = wp; last_cyc = cyc; ngnt++;
            end
            if (bus.done0 || bus.done1) begin
                n_cmp++;
                if (int'(bus.done1) !== owner || bus.rsp_rdata !== ref_mem[owner == 0 ? 5 : 10])
                begin n_fail++;
                    $display("FAIL b2b_data: done1 %b data %h want port %0d data %h", bus.done1,
                             bus.rsp_rdata, owner, ref_mem[owner == 0 ? 5 : 10]); end
                ndone++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_cmp++; if (ngnt !== 6 || ndone !== 6) begin n_fail++;
            $display("FAIL b2b_count: %0d grants %0d dones want 6/6", ngnt, ndone); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_errors();
        int gp, gw, dl, dp, rdn, wrn, bad;
        logic [31:0] rd;
        logic er;
        logic [31:0] addrs [3] = '{32'h15, 32'h100, 32'hFFFFFFFC};
        for (int i = 0; i < 3; i++) begin
            drive_req(i % 2, i == 2, addrs[i], 32'h12345678);
            observe(gp, gw, dl, dp, rd, er, rdn, wrn);
            exp_last = i % 2;
            n_cmp++;
            if (dp !== i % 2 || er !== 1'b1 || rd !== 32'd0 || rdn !== 0 || wrn !== 0) begin
                n_fail++;
                $display("FAIL err_%h: port %0d err %b data %h rd %0d wr %0d want %0d 1 0 0 0",
                         addrs[i], dp, er, rd, rdn, wrn, i % 2);
            end
        end
        bad = 0;
        for (int w = 0; w < 64; w++) if (dm_word(w) !== ref_mem[w]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL err_mem_intact: %0d words differ want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int gp, gw, dl, dp, rdn, wrn, seen = 0, ndone = 0;
        logic [31:0] rd;
        logic er;
        drive_req(0, 1'b1, 32'h28, 32'heeeeeeee);
        for (int c = 0; c < 12 && seen == 0; c++) begin
            @(posedge clk); #1;
            if (bus.gnt0) seen = 1;
        end
        bus.req0 = 1'b0;
        n_cmp++; if (seen !== 1) begin n_fail++;
            $display("FAIL rstmid_gnt: no grant seen want gnt0"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.rsp_err, bus.mem_write, bus.mem_read,
             bus.rsp_rdata, bus.mem_addr, bus.mem_wdata} !== '0) begin n_fail++;
            $display("FAIL rstmid_outputs: gnt0 %b wr %0d addr %h wdata %h want all 0",
                     bus.gnt0, bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        repeat (2) begin
            @(posedge clk); #1;
            ndone += int'(bus.done0 || bus.done1);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_last = 1;
        n_cmp++; if (ndone !== 0 || dm_word(10) !== ref_mem[10]) begin n_fail++;
            $display("FAIL rstmid_nowrite: dones %0d word %h want 0 %h", ndone, dm_word(10),
                     ref_mem[10]); end
        drive_req(0, 1'b0, 32'h28, 32'd0);
        drive_req(1, 1'b0, 32'h14, 32'd0);
        observe(gp, gw, dl, dp, rd, er, rdn, wrn);
        n_cmp++; if (gp !== 0 || rd !== 32'haaaaaaaa) begin n_fail++;
            $display("FAIL rstmid_after: port %0d data %h want 0 aaaaaaaa", gp, rd); end
        exp_last = 0;
    endtask

    task automatic test_random_access();
        int gp, gw, dl, dp, rdn, wrn, port;
        logic [31:0] rd, a, wd;
        logic er, we, ok;
        for (int i = 0; i < 40; i++) begin
            port = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 63) * 4);
                2:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                default: a = ($urandom_range(0, 1) == 0) ? 32'(256 + $urandom_range(0, 999) * 4)
                                                         : 32'hFFFFFFFC;
            endcase
            ok = is_legal(a);
            drive_req(port, we, a, wd);
            observe(gp, gw, dl, dp, rd, er, rdn, wrn);
            n_cmp++;
            if (gp !== port || dp !== port || er !== !ok || rd !== exp_rdata(we, a) ||
                rdn !== int'(ok && !we) || wrn !== int'(ok && we)) begin n_fail++;
                $display("FAIL rand_%0d: p%0d we%b a=%h got gnt%0d done%0d err%b d=%h rd%0d wr%0d",
                         i, port, we, a, gp, dp, er, rd, rdn, wrn);
                $display("  want err%b d=%h", !ok, exp_rdata(we, a));
            end
            if (ok && we) ref_mem[a / 4] = wd;
            exp_last = port;
        end
    endtask

    task automatic test_random_arb();
        int gp, gw, dl, dp, rdn, wrn, pat, wp;
        logic [31:0] rd, a0, a1;
        logic er;
        for (int i = 0; i < 24; i++) begin
            pat = int'($urandom_range(1, 3));
            a0  = 32'($urandom_range(0, 63) * 4);
            a1  = 32'($urandom_range(0, 63) * 4);
            if (pat == 3) wp = (exp_last == 0) ? 1 : 0;
            else wp = (pat == 1) ? 0 : 1;
            if (pat % 2 == 1) drive_req(0, 1'b0, a0, 32'd0);
            if (pat >= 2) drive_req(1, 1'b0, a1, 32'd0);
            observe(gp, gw, dl, dp, rd, er, rdn, wrn);
            n_cmp++;
            if (gp !== wp || dp !== wp || rd !== ref_mem[(wp == 0 ? a0 : a1) / 4]) begin
                n_fail++;
                $display("FAIL arb_%0d: pat %0d got port %0d data %h want port %0d data %h", i,
                         pat, gp, rd, wp, ref_mem[(wp == 0 ? a0 : a1) / 4]);
            end
            exp_last = wp;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 256; i++) dm[i] = 8'h00;
        for (int i = 20; i < 24; i++) dm[i] = 8'h55;
        for (int i = 40; i < 44; i++) dm[i] = 8'haa;
        for (int w = 0; w < 64; w++) ref_mem[w] = 32'd0;
        ref_mem[5]  = 32'h55555555;
        ref_mem[10] = 32'haaaaaaaa;

        test_reset();
        test_plan_reads();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random_access();
        test_random_arb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and access sequencer for the byte-addressed, 32-bit-word `DataMem`. It lets two requesters share the single memory port: port 0 is the CPU load/store stage and port 1 is the debug/loader port. The block serialises their word reads and writes with round-robin fairness and drives `DataMem`'s `Address`/`WriteData`/`MemWrite`/`MemRead`. It returns read data and completion/error status per port, and rejects misaligned or out-of-range accesses without touching memory.

## Interface
- `ADDR_LIMIT`, default 256: memory size in bytes. Legal word addresses are `0 .. ADDR_LIMIT-4`.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0` / `req1` in 1: access request from port 0 / port 1. Held high until `gntN` is seen.
- `we0` / `we1` in 1: 1 = write, 0 = read. Sampled with the request.
- `addr0` / `addr1` in 32: byte address of the word.
- `wdata0` / `wdata1` in 32: write data.
- `gnt0` / `gnt1` out 1: one-cycle pulse. The request has been accepted and its fields latched.
- `done0` / `done1` out 1: one-cycle pulse. The access has completed and `rsp_*` are valid.
- `rsp_rdata` out 32: read data (0 for writes and errors). Valid only while some `doneN` = 1.
- `rsp_err` out 1: misaligned or out-of-range access. Valid only while some `doneN` = 1.
- `mem_addr` out 32: to `DataMem` `Address`.
- `mem_wdata` out 32: to `DataMem` `WriteData`.
- `mem_write` out 2: to `DataMem` `MemWrite`. Only values 0 and 1 are driven.
- `mem_read` out 2: to `DataMem` `MemRead`. Only values 0 and 1 are driven.
- `mem_rdata` in 32: from `DataMem` `ReadData`. Combinational read of the currently addressed word.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, with a request:
  - Pick the winner (see next bullet).
  - Latch its `we`, `addr` and `wdata`.
  - Pulse its `gnt`.
  - Go to ACCESS.
- Winner selection:
  - If only one `reqN` is high, that port wins.
  - If both are high, the port not served most recently wins.
  - The priority pointer resets to favour port 0. It updates on every grant, including error grants.
- Access check: the access is legal if `addr[1:0] == 0` and `addr <= ADDR_LIMIT-4`, evaluated as an unsigned 32-bit compare. Any other access is an error.
- ACCESS, legal access:
  - `mem_addr` = latched address.
  - For a write: `mem_write` = 1 and `mem_wdata` = latched data.
  - For a read: `mem_read` = 1.
  - For exactly one cycle, then go to RESP.
- ACCESS, error access: both strobes stay 0 and `mem_addr` holds its previous value.
- Capture at the end of ACCESS:
  - Legal read: `rsp_rdata` <= `mem_rdata`.
  - Write: `rsp_rdata` <= 0.
  - Error: `rsp_rdata` <= 0 and `rsp_err` <= 1.
- RESP: pulse the owner's `doneN`, then go to IDLE.
- Requests are never sampled in ACCESS or RESP. A `req` still high in IDLE is a new request.
- A request dropped before its `gnt` is simply lost; no access is made.
- Reset, at any time including mid-access:
  - All outputs go to 0 immediately, so any strobe in flight is withdrawn.
  - State goes to IDLE and the pointer favours port 0.
  - A write whose ACCESS clock edge has not yet occurred is not performed.

## Timing
- All outputs are registered; none is combinational from `reqN`.
- For a request sampled at edge E0:
  - `gntN` and the `mem_*` strobes are high between E0 and E1.
  - `DataMem` writes at E1.
  - `doneN`, `rsp_*` are high between E1 and E2.
  - State is back in IDLE after E2, so the earliest next grant is at E3.
- Latency: 2 cycles from request to done. Throughput: one access per 3 cycles.
- A requester must deassert or change `req` on the edge after it sees `gnt`.

## Test plan
- Preload `DM[20..23]` = `0x55`, `DM[40..43]` = `0xaa`.
  - Port 0 read 0x14 -> `gnt0` at E0, `mem_read` = 1 for one cycle, `done0` with `rsp_rdata` = `0x55555555`, `rsp_err` = 0.
  - Port 0 read 0x28 -> `done0` with `rsp_rdata` = `0xaaaaaaaa`.
- Port 1 write `0x99999999` to 0x14 -> `mem_write` = 1 for exactly one cycle, `done1` with `rsp_rdata` = 0. A following read of 0x14 -> `0x99999999`.
- `req0` and `req1` both held high continuously, each re-requesting after done, reads of 0x14 and 0x28 -> grants alternate 0, 1, 0, 1 starting with port 0. Each port sees its own data. No grant occurs within 3 cycles of the previous one.
- Read 0x15, read 0x100, and write 0xFFFFFFFC (with `ADDR_LIMIT` = 256) -> `done` with `rsp_err` = 1, `rsp_rdata` = 0. `mem_read`/`mem_write` stay 0 throughout, and the memory contents are unchanged.
- Write `0xeeeeeeee` to 0x28, then assert `rst` mid-cycle during ACCESS before the edge -> all outputs 0 at once and no `done`. A read of 0x28 after reset returns `0xaaaaaaaa`, and the next simultaneous request is granted to port 0.
